multicycle_control: RTL and testbench

Multi-cycle MIPS control unit; successor to the single-cycle main decoder. Moore FSM sequences each instruction through fetch/decode/execute/memory/writeback states and drives datapath enables and mux selects from the current state. Adds beq, j and addi to R-type/lw/sw, a parametrised memory wait, and illegal-opcode trapping. Sits between the instruction register (opcode source) and the shared-memory multi-cycle datapath.

---
 rtl/mc_ctrl_pkg.sv | 50 +++++
 rtl/multicycle_control_if.sv | 36 +++
 rtl/mc_opcode_class.sv | 26 ++
 rtl/multicycle_control.sv | 142 ++++++++++++++
 tb/tb_multicycle_control.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// State values double as the debug state output, so their numbering is fixed.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_LOAD,
    CL_STORE,
    CL_BEQ,
    CL_JUMP,
    CL_ADDI,
    CL_ILLEGAL
  } op_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit to datapath bundle: opcode from the IR in, enables and selects out.
// master is the control unit, slave is the datapath side.
interface multicycle_control_if;

  logic [5:0] opcode;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       reg_write;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode,
    output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, illegal, state
  );

  modport slave (
    output opcode,
    input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, illegal, state
  );

endinterface

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier; optional instructions fold into CL_ILLEGAL
// when their enable parameter is cleared.
module mc_opcode_class
  import mc_ctrl_pkg::*;
#(
  parameter bit EN_ADDI = 1'b1,
  parameter bit EN_J    = 1'b1
) (
  input  logic [5:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = CL_ILLEGAL;
    case (opcode)
      OP_RTYPE: op_class = CL_RTYPE;
      OP_LW:    op_class = CL_LOAD;
      OP_SW:    op_class = CL_STORE;
      OP_BEQ:   op_class = CL_BEQ;
      OP_J:     op_class = EN_J    ? CL_JUMP : CL_ILLEGAL;
      OP_ADDI:  op_class = EN_ADDI ? CL_ADDI : CL_ILLEGAL;
      default:  op_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing fetch/decode/execute/memory/writeback for a multi-cycle
// MIPS datapath, with a shared wait counter for MEM_LAT-cycle memory accesses.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter bit EN_ADDI = 1'b1,
  parameter bit EN_J    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  op_class_t     op_class;
  logic          wait_done;

  mc_opcode_class #(.EN_ADDI(EN_ADDI), .EN_J(EN_J)) u_class (
    .opcode   (bus.opcode),
    .op_class (op_class)
  );

  assign wait_done = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: if (wait_done) state_d = S_DECODE; else cnt_d = cnt_q + CW'(1);
      S_DECODE: begin
        case (op_class)
          CL_RTYPE: state_d = S_EXEC;
          CL_LOAD,
          CL_STORE: state_d = S_MEM_ADDR;
          CL_BEQ:   state_d = S_BRANCH;
          CL_JUMP:  state_d = S_JUMP;
          CL_ADDI:  state_d = S_ADDI_EX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (op_class == CL_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (wait_done) state_d = S_MEM_WB; else cnt_d = cnt_q + CW'(1);
      S_MEM_WR:  if (wait_done) state_d = S_FETCH;  else cnt_d = cnt_q + CW'(1);
      S_EXEC:    state_d = S_R_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      default:   state_d = S_FETCH;
    endcase
    // Every state change restarts the wait count for the next memory state.
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_source     = PCSRC_ALU;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_REGB;
    bus.alu_op        = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.ir_write  = wait_done;
        bus.pc_write  = wait_done;
      end
      S_DECODE:   bus.alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = PCSRC_JUMP;
      end
      S_ADDI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: bus.reg_write = 1'b1;
      default: ;
    endcase
  end

  assign bus.state   = state_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: two control units (MEM_LAT=1 full ISA, MEM_LAT=3 without addi)
// driven by directed and random instruction streams against an instruction-level model.
module tb_multicycle_control;

  logic       clk;
  logic       rst_v [2];
  logic [5:0] opc   [2];
  bit         sticky [2];
  int         checks = 0;
  int         errors = 0;
  int         cyc   [2];
  logic [20:0] q0 [$];
  logic [20:0] q1 [$];

  multicycle_control_if ifa ();
  multicycle_control_if ifb ();

  assign ifa.opcode = opc[0];
  assign ifb.opcode = opc[1];

  multicycle_control #(.MEM_LAT(1), .EN_ADDI(1'b1), .EN_J(1'b1)) dut_a (
    .clk (clk), .rst (rst_v[0]), .bus (ifa.master)
  );

  multicycle_control #(.MEM_LAT(3), .EN_ADDI(1'b0), .EN_J(1'b1)) dut_b (
    .clk (clk), .rst (rst_v[1]), .bus (ifb.master)
  );

  wire [20:0] obs_a = {ifa.state, ifa.illegal, ifa.pc_write, ifa.pc_write_cond, ifa.pc_source,
                       ifa.iord, ifa.mem_read, ifa.mem_write, ifa.ir_write, ifa.reg_dst,
                       ifa.reg_write, ifa.mem_to_reg, ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op};
  wire [20:0] obs_b = {ifb.state, ifb.illegal, ifb.pc_write, ifb.pc_write_cond, ifb.pc_source,
                       ifb.iord, ifb.mem_read, ifb.mem_write, ifb.ir_write, ifb.reg_dst,
                       ifb.reg_write, ifb.mem_to_reg, ifb.alu_src_a, ifb.alu_src_b, ifb.alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(int idx);
    return (idx == 0) ? 1 : 3;
  endfunction

  function automatic bit addi_ok(int idx);
    return idx == 0;
  endfunction

  // Expected control word for one cycle spent in phase ph (phase number = state number).
  function automatic logic [20:0] expect_vec(int ph, bit last, bit ill);
    logic       pw, pwc, iord, mr, mw, irw, rd, rw, m2r, asa;
    logic [1:0] ps, asb, aop;
    {pw, pwc, iord, mr, mw, irw, rd, rw, m2r, asa} = '0;
    ps = 2'b00; asb = 2'b00; aop = 2'b00;
    case (ph)
      0:  begin mr = 1; asb = 2'b01; irw = last; pw = last; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {4'(ph), ill, pw, pwc, ps, iord, mr, mw, irw, rd, rw, m2r, asa, asb, aop};
  endfunction

  task automatic push_exp(int idx, logic [20:0] v);
    if (idx == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic push_fetch(int idx);
    for (int i = 0; i < lat(idx); i++)
      push_exp(idx, expect_vec(0, i == lat(idx) - 1, sticky[idx]));
  endtask

  task automatic applyReset(int idx, int n, bit first);
    rst_v[idx] = 1'b1;
    if (!first) push_exp(idx, expect_vec(0, lat(idx) == 1, sticky[idx]));
    else begin @(posedge clk); #1; end
    sticky[idx] = 1'b0;
    for (int i = 0; i < n - 1; i++) begin
      push_exp(idx, expect_vec(0, lat(idx) == 1, 1'b0));
      @(posedge clk); #1;
    end
    if (!first) begin @(posedge clk); #1; end
    rst_v[idx] = 1'b0;
  endtask

  // One instruction from its first FETCH cycle back to the next FETCH.
  task automatic applyStimulus(int idx, logic [5:0] op);
    int ph [$];
    int L;
    bit bad;
    L = lat(idx);
    opc[idx] = op;
    push_fetch(idx);
    push_exp(idx, expect_vec(1, 1'b0, sticky[idx]));
    bad = 1'b0;
    case (op)
      6'b000000: ph = '{6, 7};
      6'b100011: begin ph.push_back(2); repeat (L) ph.push_back(3); ph.push_back(4); end
      6'b101011: begin ph.push_back(2); repeat (L) ph.push_back(5); end
      6'b000100: ph = '{8};
      6'b000010: ph = '{9};
      6'b001000: if (addi_ok(idx)) ph = '{10, 11}; else bad = 1'b1;
      default:   bad = 1'b1;
    endcase
    if (bad) sticky[idx] = 1'b1;
    foreach (ph[k]) push_exp(idx, expect_vec(ph[k], 1'b0, sticky[idx]));
    repeat (L + 1 + ph.size()) @(posedge clk);
    #1;
  endtask

  // Store aborted by reset during its second memory wait cycle.
  task automatic applyAbort(int idx);
    int L;
    L = lat(idx);
    opc[idx] = 6'b101011;
    push_fetch(idx);
    push_exp(idx, expect_vec(1, 1'b0, sticky[idx]));
    push_exp(idx, expect_vec(2, 1'b0, sticky[idx]));
    push_exp(idx, expect_vec(5, 1'b0, sticky[idx]));
    push_exp(idx, expect_vec(5, 1'b0, sticky[idx]));
    repeat (L + 3) @(posedge clk);
    #1;
    rst_v[idx] = 1'b1;
    @(posedge clk); #1;
    rst_v[idx] = 1'b0;
    sticky[idx] = 1'b0;
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [6];
    int r;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    r = $urandom_range(0, 7);
    return (r < 6) ? ops[r] : 6'($urandom_range(0, 63));
  endfunction

  task automatic checkOutput(int idx, logic [20:0] exp, logic [20:0] act);
    checks++;
    if (exp !== act) begin
      errors++;
      $display("[TB] FAIL ctrl_word dut%0d cycle %0d: got %h (state %0d) expected %h (state %0d)",
               idx, cyc[idx], act, act[20:17], exp, exp[20:17]);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) begin checkOutput(0, q0.pop_front(), obs_a); cyc[0]++; end
    if (q1.size() > 0) begin checkOutput(1, q1.pop_front(), obs_b); cyc[1]++; end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [5:0] seq_a [6];
    logic [5:0] seq_b [7];
    seq_a = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    seq_b = '{6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b111111, 6'b001000, 6'b100011};
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    opc[0] = '0; opc[1] = '0;
    sticky[0] = 1'b0; sticky[1] = 1'b0;
    cyc[0] = 0; cyc[1] = 0;
    fork
      begin
        applyReset(0, 2, 1'b1);
        foreach (seq_a[i]) applyStimulus(0, seq_a[i]);
        repeat (40) begin
          if ($urandom_range(0, 9) == 0) applyReset(0, 1, 1'b0);
          applyStimulus(0, rand_op());
        end
      end
      begin
        applyReset(1, 2, 1'b1);
        foreach (seq_b[i]) applyStimulus(1, seq_b[i]);
        applyAbort(1);
        applyStimulus(1, 6'b100011);
        repeat (30) begin
          if ($urandom_range(0, 9) == 0) applyReset(1, 1, 1'b0);
          applyStimulus(1, rand_op());
        end
      end
    join
    @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d/%0d pending expectations, expected 0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
